// File: rtl/udp_tx_packetizer.sv
// rtl/udp_tx_packetizer.sv - byte-stream to UDP payload framer for the eth UDP TX port
//
// Buffers user bytes in a RAM FIFO and launches a UDP frame toward eth either
// when MAX_LEN bytes are buffered or when the stream has gone idle for TIMEOUT
// cycles with a partial payload pending. Payload bytes are served one cycle
// after each udp_tx_req.
//
// Ports:
//   clk              gmii_tx_clk, rising edge
//   rst_n            asynchronous reset, active low
//   in_data/in_vld   user payload byte and its valid
//   in_rdy           byte accepted when in_vld & in_rdy (FIFO not full)
//   tx_rdy           eth transmitter idle
//   udp_tx_en        1-cycle frame start pulse
//   udp_tx_data_num  payload length of the launched frame, held until next launch
//   udp_tx_req       eth request for the next payload byte
//   udp_tx_data      payload byte, valid the cycle after udp_tx_req
//   frame_done       1-cycle pulse after the last byte of a frame is returned
//   req_err          sticky flag for requests outside SEND or beyond frame length
module udp_tx_packetizer #(
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = 1024,
    parameter int TIMEOUT = 125000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic        tx_rdy,
    output logic        udp_tx_en,
    output logic [15:0] udp_tx_data_num,
    input  logic        udp_tx_req,
    output logic [7:0]  udp_tx_data,
    output logic        frame_done,
    output logic        req_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = $clog2(TIMEOUT);

    localparam logic [ADDR_W:0] FULL_C    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MAX_LEN_C = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_SEND
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [TW-1:0]     timer_q;
    logic [15:0]       len_q, len_d;
    logic [15:0]       remaining_q;
    logic [15:0]       num_q;
    logic [7:0]        data_q;
    logic              en_q, done_q, err_q;
    logic              wr, rd;

    assign in_rdy = (count_q != FULL_C);
    assign wr     = in_vld & in_rdy;
    // Pops only happen for requests inside a live frame; anything else is an error.
    assign rd     = (state_q == S_SEND) && udp_tx_req && (remaining_q != 16'd0);

    assign udp_tx_en       = en_q;
    assign udp_tx_data_num = num_q;
    assign udp_tx_data     = data_q;
    assign frame_done      = done_q;
    assign req_err         = err_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                // Full-frame launch wins over the idle-timeout flush.
                if (count_q >= MAX_LEN_C) begin
                    len_d   = 16'(MAX_LEN);
                    state_d = S_WAIT_RDY;
                end else if ((count_q != '0) && (timer_q == T_LAST)) begin
                    len_d   = 16'(count_q);
                    state_d = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (tx_rdy) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (remaining_q == 16'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Payload RAM: no reset, contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            num_q       <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_q + (ADDR_W + 1)'(wr) - (ADDR_W + 1)'(rd);

            if (wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                data_q   <= mem[rd_ptr_q];
            end

            // Idle timer only runs while data is pending and no frame is in flight.
            if (wr || (count_q == '0)) begin
                timer_q <= '0;
            end else if ((state_q == S_IDLE) && (timer_q != T_LAST)) begin
                timer_q <= timer_q + TW'(1);
            end

            en_q <= (state_q == S_WAIT_RDY) && tx_rdy;
            if ((state_q == S_WAIT_RDY) && tx_rdy) begin
                num_q       <= len_q;
                remaining_q <= len_q;
            end else if (rd) begin
                remaining_q <= remaining_q - 16'd1;
            end

            // Fires on the cycle the FSM leaves SEND, i.e. one cycle after the last byte appears.
            done_q <= (state_q == S_SEND) && (remaining_q == 16'd0);
            err_q  <= err_q | (udp_tx_req & ~rd);
        end
    end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// tb/tb_udp_tx_packetizer.sv - directed self-checking bench for udp_tx_packetizer
module tb_udp_tx_packetizer;

    localparam int ADDR_W  = 11;
    localparam int MAX_LEN = 1024;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic        tx_rdy = 1'b1;
    logic        udp_tx_en;
    logic [15:0] udp_tx_data_num;
    logic        udp_tx_req = 1'b0;
    logic [7:0]  udp_tx_data;
    logic        frame_done;
    logic        req_err;

    int checks = 0;
    int errors = 0;
    int wr_seq = 0;
    int rd_seq = 0;
    int en_cnt = 0;
    int en_seen = 0;

    typedef struct {
        int n_wr;
        int num1;
        int cnt_after;
        int num2;
        int lat;
    } vec_t;

    vec_t vecs [5];

    udp_tx_packetizer #(
        .ADDR_W (ADDR_W),
        .MAX_LEN(MAX_LEN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .tx_rdy         (tx_rdy),
        .udp_tx_en      (udp_tx_en),
        .udp_tx_data_num(udp_tx_data_num),
        .udp_tx_req     (udp_tx_req),
        .udp_tx_data    (udp_tx_data),
        .frame_done     (frame_done),
        .req_err        (req_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (udp_tx_en === 1'b1) en_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_n(input int n, input int budget, output int acc);
        int cyc;
        cyc = 0;
        acc = 0;
        while (acc < n && cyc < budget) begin
            @(negedge clk);
            in_vld  = 1'b1;
            in_data = wr_seq[7:0];
            if (in_rdy) begin
                acc++;
                wr_seq++;
            end
            cyc++;
        end
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic wait_en(input int exp_num, input int exp_lat, input string name);
        int cyc;
        cyc = 0;
        while (en_cnt == en_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " en pulses"}, en_cnt - en_seen, 1);
        en_seen = en_cnt;
        chk({name, " num"}, udp_tx_data_num, exp_num);
        if (exp_lat >= 0) chk({name, " launch latency"}, cyc, exp_lat);
    endtask

    task automatic read_frame(input int n, input bit extra, input string name);
        int bad;
        int first_i;
        int first_act;
        int first_exp;
        int last_b;
        bad = 0;
        first_i = -1;
        first_act = 0;
        first_exp = 0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            udp_tx_req = (i < n) ? 1'b1 : extra;
            if (i > 0) begin
                if (udp_tx_data !== rd_seq[7:0]) begin
                    if (bad == 0) begin
                        first_i = i - 1;
                        first_act = udp_tx_data;
                        first_exp = rd_seq[7:0];
                    end
                    bad++;
                end
                rd_seq++;
            end
        end
        last_b = rd_seq - 1;
        chk({name, " frame_done early"}, frame_done, 0);
        @(negedge clk);
        udp_tx_req = 1'b0;
        chk({name, " frame_done"}, frame_done, 1);
        if (extra) chk({name, " data held after extra req"}, udp_tx_data, last_b & 8'hff);
        @(negedge clk);
        chk({name, " frame_done width"}, frame_done, 0);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s data: %0d bad bytes, first at %0d got %0d expected %0d",
                     name, bad, first_i, first_act, first_exp);
        end
    endtask

    initial begin
        int acc;
        int bad;

        vecs[0] = '{n_wr: 1024, num1: 1024, cnt_after: 0, num2: 0, lat: 2};
        vecs[1] = '{n_wr: 10,   num1: 10,   cnt_after: 0, num2: 0, lat: 101};
        vecs[2] = '{n_wr: 1,    num1: 1,    cnt_after: 0, num2: 0, lat: 101};
        vecs[3] = '{n_wr: 1023, num1: 1023, cnt_after: 0, num2: 0, lat: 101};
        vecs[4] = '{n_wr: 1030, num1: 1024, cnt_after: 6, num2: 6, lat: -1};

        repeat (2) @(negedge clk);
        chk("reset in_rdy", in_rdy, 1);
        chk("reset udp_tx_en", udp_tx_en, 0);
        chk("reset num", udp_tx_data_num, 0);
        chk("reset udp_tx_data", udp_tx_data, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset req_err", req_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            write_n(vecs[v].n_wr, vecs[v].n_wr + 10, acc);
            chk($sformatf("vec%0d accepted", v), acc, vecs[v].n_wr);
            wait_en(vecs[v].num1, vecs[v].lat, $sformatf("vec%0d f1", v));
            read_frame(vecs[v].num1, 1'b0, $sformatf("vec%0d f1", v));
            chk($sformatf("vec%0d count after f1", v), int'(dut.count_q), vecs[v].cnt_after);
            if (vecs[v].num2 > 0) begin
                wait_en(vecs[v].num2, -1, $sformatf("vec%0d f2", v));
                read_frame(vecs[v].num2, 1'b0, $sformatf("vec%0d f2", v));
                chk($sformatf("vec%0d count after f2", v), int'(dut.count_q), 0);
            end
        end

        // Fill with eth busy: exactly DEPTH bytes go in, no launch until tx_rdy.
        tx_rdy = 1'b0;
        write_n(2100, 2100, acc);
        chk("fill accepted", acc, 2048);
        chk("fill in_rdy", in_rdy, 0);
        repeat (20) @(negedge clk);
        chk("fill no en while busy", en_cnt - en_seen, 0);
        tx_rdy = 1'b1;
        wait_en(1024, -1, "fill f1");
        read_frame(1024, 1'b0, "fill f1");
        wait_en(1024, -1, "fill f2");
        read_frame(1024, 1'b0, "fill f2");
        chk("fill count end", int'(dut.count_q), 0);

        // Writes concurrent with the SEND of a full frame.
        write_n(1024, 1100, acc);
        wait_en(1024, -1, "concur A");
        fork
            read_frame(1024, 1'b0, "concur A");
            write_n(300, 400, acc);
        join
        chk("concur count", int'(dut.count_q), 300);
        wait_en(300, -1, "concur B");
        read_frame(300, 1'b0, "concur B");

        // One request beyond frame length, then one in IDLE.
        chk("err before", req_err, 0);
        write_n(1024, 1100, acc);
        wait_en(1024, -1, "err");
        read_frame(1024, 1'b1, "err");
        chk("err after extra req", req_err, 1);
        repeat (5) @(negedge clk);
        udp_tx_req = 1'b1;
        @(negedge clk);
        udp_tx_req = 1'b0;
        chk("err idle req sticky", req_err, 1);
        chk("err count unaffected", int'(dut.count_q), 0);
        write_n(10, 20, acc);
        wait_en(10, 101, "err post");
        read_frame(10, 1'b0, "err post");
        chk("err still sticky", req_err, 1);

        // Reset in the middle of a frame.
        write_n(1024, 1100, acc);
        wait_en(1024, -1, "rst");
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            udp_tx_req = 1'b1;
            if (i > 0) begin
                if (udp_tx_data !== rd_seq[7:0]) bad++;
                rd_seq++;
            end
        end
        chk("rst partial data bad bytes", bad, 0);
        @(negedge clk);
        udp_tx_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst in_rdy", in_rdy, 1);
        chk("rst udp_tx_en", udp_tx_en, 0);
        chk("rst num", udp_tx_data_num, 0);
        chk("rst udp_tx_data", udp_tx_data, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst req_err", req_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst count", int'(dut.count_q), 0);
        chk("rst in_rdy after", in_rdy, 1);
        en_seen = en_cnt;
        rd_seq = wr_seq;
        repeat (150) @(negedge clk);
        chk("rst no stale en", en_cnt - en_seen, 0);
        write_n(5, 10, acc);
        wait_en(5, 101, "rst post");
        read_frame(5, 1'b0, "rst post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
